// File: rtl/sbox_pkg.sv
// Shared types and constants for the run-time inverse S-box builder.
package sbox_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BUILD = 3'd1,
        ST_CHECK = 3'd2,
        ST_READY = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int         TABLE_DEPTH = 256;
    localparam logic [7:0] LAST_IDX    = 8'hFF;

    // Known AES pairs: forward output -> inverse value (inv(TV_Qn) == TV_Rn).
    localparam logic [7:0] TV_Q0 = 8'h63;
    localparam logic [7:0] TV_R0 = 8'h00;
    localparam logic [7:0] TV_Q1 = 8'h7C;
    localparam logic [7:0] TV_R1 = 8'h01;
    localparam logic [7:0] TV_Q2 = 8'h16;
    localparam logic [7:0] TV_R2 = 8'hFF;
    localparam logic [7:0] TV_Q3 = 8'h52;
    localparam logic [7:0] TV_R3 = 8'h48;

endpackage

// File: rtl/sbox_inv_ram.sv
// Simple dual-port table: one synchronous write, one registered read, no reset.
module sbox_inv_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register only updates on an accepted query so the response holds under backpressure.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sbox_inv_builder.sv
// Builds the inverse S-box by sweeping the forward lookup, checks bijectivity,
// then serves inverse lookups over a valid/ready handshake.
module sbox_inv_builder
    import sbox_pkg::*;
#(
    parameter int ADDR_W          = 8,
    parameter bit CHECK_BIJECTIVE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] fwd_addr,
    input  logic [ADDR_W-1:0] fwd_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [ADDR_W-1:0] r_data
);

    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_IDX);

    state_t            state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [DEPTH-1:0]  seen_reg;
    logic              dup_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;
    logic              r_valid_reg;
    logic [ADDR_W-1:0] ram_rdata;

    logic start_ok;
    logic build_wr;
    logic q_fire;

    assign start_ok = start && ((state_reg == ST_IDLE) ||
                                (state_reg == ST_READY) ||
                                (state_reg == ST_ERR));
    assign build_wr = (state_reg == ST_BUILD);
    assign q_ready  = (state_reg == ST_READY) && (!r_valid_reg || r_ready);
    assign q_fire   = q_valid && q_ready;

    assign fwd_addr = idx_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign error    = error_reg;
    assign r_valid  = r_valid_reg;
    // RAM output is unreset; mask it so r_data reads 0 whenever no response is pending.
    assign r_data   = r_valid_reg ? ram_rdata : '0;

    // One seen flag per table entry, cleared at every build start.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_seen
            always_ff @(posedge clk) begin
                if (rst || start_ok) begin
                    seen_reg[gi] <= 1'b0;
                end else if (build_wr && (fwd_data == ADDR_W'(gi))) begin
                    seen_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            dup_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            r_valid_reg <= 1'b0;
        end else begin
            if (q_fire) begin
                r_valid_reg <= 1'b1;
            end else if (r_ready) begin
                r_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE, ST_READY, ST_ERR: begin
                    if (start_ok) begin
                        state_reg   <= ST_BUILD;
                        idx_reg     <= '0;
                        dup_reg     <= 1'b0;
                        busy_reg    <= 1'b1;
                        done_reg    <= 1'b0;
                        error_reg   <= 1'b0;
                        r_valid_reg <= 1'b0;
                    end
                end
                ST_BUILD: begin
                    if (seen_reg[fwd_data]) begin
                        dup_reg <= 1'b1;
                    end
                    if (idx_reg == LAST) begin
                        state_reg <= ST_CHECK;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                ST_CHECK: begin
                    busy_reg <= 1'b0;
                    if (CHECK_BIJECTIVE && dup_reg) begin
                        state_reg <= ST_ERR;
                        error_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_READY;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    error_reg <= 1'b0;
                end
            endcase
        end
    end

    sbox_inv_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (build_wr),
        .waddr (fwd_data),
        .wdata (idx_reg),
        .re    (q_fire),
        .raddr (q_addr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_sbox_inv_builder.sv
// Self-checking bench: AES forward table from GF(2^8) arithmetic, cycle model of the
// builder's visible behaviour, plus directed literal checks.
module tb_sbox_inv_builder;
    import sbox_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] fwd_addr;
    logic [7:0] fwd_data;
    logic       busy, done, error;
    logic       q_valid, q_ready;
    logic [7:0] q_addr;
    logic       r_valid, r_ready;
    logic [7:0] r_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];
    logic       fault;
    logic       cmp_en = 1'b0;

    always #5 clk = ~clk;

    sbox_inv_builder #(.ADDR_W(8), .CHECK_BIJECTIVE(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_addr   (q_addr),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_data   (r_data)
    );

    // Forward lookup stand-in, with an optional planted collision at address 0x01.
    always_comb begin
        fwd_data = fwd_tbl[fwd_addr];
        if (fault && (fwd_addr == 8'h01)) fwd_data = 8'h63;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < 254; k++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic bit table_has_dup();
        bit seen [256];
        logic [7:0] v;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 256; k++) begin
            v = fwd_tbl[k];
            if (fault && (k == 1)) v = 8'h63;
            if (seen[v]) return 1'b1;
            seen[v] = 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: modes and a cycle count since the accepted start.
    localparam int M_IDLE = 0, M_BUILD = 1, M_READY = 2, M_ERR = 3;
    int         m_mode;
    int         m_cnt;
    bit         m_bad;
    logic       m_rvalid;
    logic [7:0] m_rdata;
    logic       exp_q_ready;

    assign exp_q_ready = (m_mode == M_READY) && (!m_rvalid || r_ready);

    always @(posedge clk) begin
        if (rst) begin
            m_mode   <= M_IDLE;
            m_cnt    <= 0;
            m_rvalid <= 1'b0;
            m_rdata  <= 8'h00;
        end else if (start && (m_mode != M_BUILD)) begin
            m_mode   <= M_BUILD;
            m_cnt    <= 0;
            m_bad    <= table_has_dup();
            m_rvalid <= 1'b0;
        end else begin
            if (m_mode == M_BUILD) begin
                if (m_cnt == 256) m_mode <= m_bad ? M_ERR : M_READY;
                m_cnt <= m_cnt + 1;
            end
            if (exp_q_ready && q_valid) begin
                m_rvalid <= 1'b1;
                m_rdata  <= inv_tbl[q_addr];
            end else if (r_ready) begin
                m_rvalid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", busy, m_mode == M_BUILD);
            chk("cyc_done", done, m_mode == M_READY);
            chk("cyc_error", error, m_mode == M_ERR);
            chk("cyc_q_ready", q_ready, exp_q_ready);
            chk("cyc_r_valid", r_valid, m_rvalid);
            if (m_rvalid) chk("cyc_r_data", r_data, m_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, optionally pulse start again at i == inj, then wait for done/error.
    task automatic run_build(input int inj, output int edges, output int busy_cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        busy_cnt = 0;
        while (!(done || error) && edges < 400) begin
            if (busy) busy_cnt++;
            start = (edges == inj + 1);
            tick();
            start = 1'b0;
            edges++;
        end
        if (edges >= 400) chk("build_timeout", 0, 1);
    endtask

    logic [7:0] tv_q [4];
    logic [7:0] tv_r [4];

    task automatic query_burst(input string tag);
        q_valid = 1'b1;
        r_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            q_addr = tv_q[j];
            tick();
            chk({tag, "_r_valid"}, r_valid, 1);
            chk({tag, "_r_data"}, r_data, tv_r[j]);
        end
        q_valid = 1'b0;
        tick();
        chk({tag, "_r_valid_drop"}, r_valid, 0);
    endtask

    int edges, busy_cnt;

    initial begin
        rst = 1'b1; start = 1'b0; q_valid = 1'b0; q_addr = 8'h00;
        r_ready = 1'b0; fault = 1'b0;
        tv_q[0] = TV_Q0; tv_q[1] = TV_Q1; tv_q[2] = TV_Q2; tv_q[3] = TV_Q3;
        tv_r[0] = TV_R0; tv_r[1] = TV_R1; tv_r[2] = TV_R2; tv_r[3] = TV_R3;
        for (int k = 0; k < TABLE_DEPTH; k++) fwd_tbl[k] = aes_sbox(8'(k));
        for (int k = 0; k < TABLE_DEPTH; k++) inv_tbl[fwd_tbl[k]] = 8'(k);

        // Pin the model against published AES entries.
        chk("model_sbox_00", fwd_tbl[0], 8'h63);
        chk("model_sbox_01", fwd_tbl[1], 8'h7C);
        chk("model_sbox_48", fwd_tbl[8'h48], 8'h52);
        chk("model_sbox_ff", fwd_tbl[8'hFF], 8'h16);
        chk("model_inv_52", inv_tbl[8'h52], 8'h48);

        // 1. reset
        tick();
        tick();
        cmp_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_q_ready", q_ready, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_fwd_addr", fwd_addr, 0);
        rst = 1'b0;
        $display("txn reset done");

        // 2. correct build
        run_build(-10, edges, busy_cnt);
        chk("build_latency", edges, 258);
        chk("build_busy_cycles", busy_cnt, 257);
        chk("build_done", done, 1);
        chk("build_error", error, 0);
        $display("txn build edges=%0d busy=%0d done=%0b error=%0b", edges, busy_cnt, done, error);

        // 3. back-to-back queries
        query_burst("q3");
        $display("txn burst queries complete");

        // 4. backpressure
        q_valid = 1'b1; q_addr = TV_Q0; r_ready = 1'b0;
        tick();
        q_addr = TV_Q1;
        for (int j = 0; j < 3; j++) begin
            chk("bp_r_valid", r_valid, 1);
            chk("bp_r_data", r_data, TV_R0);
            chk("bp_q_ready", q_ready, 0);
            tick();
        end
        r_ready = 1'b1;
        #1;
        chk("bp_release_q_ready", q_ready, 1);
        tick();
        chk("bp_next_r_data", r_data, TV_R1);
        q_valid = 1'b0;
        tick();
        chk("bp_drop", r_valid, 0);
        $display("txn backpressure r_data=%0h", r_data);

        // 5. faulty forward table, then recovery
        fault = 1'b1;
        run_build(-10, edges, busy_cnt);
        chk("fault_latency", edges, 258);
        chk("fault_error", error, 1);
        chk("fault_done", done, 0);
        q_valid = 1'b1; q_addr = TV_Q0;
        for (int j = 0; j < 3; j++) begin
            chk("fault_q_ready", q_ready, 0);
            tick();
        end
        chk("fault_no_resp", r_valid, 0);
        q_valid = 1'b0;
        fault = 1'b0;
        $display("txn fault build error=%0b done=%0b", error, done);
        run_build(-10, edges, busy_cnt);
        chk("recover_latency", edges, 258);
        chk("recover_done", done, 1);
        chk("recover_error", error, 0);
        $display("txn recovery build done=%0b", done);

        // 6a. start ignored mid-build
        run_build(100, edges, busy_cnt);
        chk("restart_ignored_latency", edges, 258);
        chk("restart_ignored_done", done, 1);
        $display("txn mid-build start edges=%0d", edges);

        // 6b. reset mid-build, then rebuild and query
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 100; j++) tick();
        chk("midrst_idx", fwd_addr, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_fwd_addr", fwd_addr, 0);
        run_build(-10, edges, busy_cnt);
        chk("midrst_rebuild_latency", edges, 258);
        query_burst("q6");
        $display("txn reset-rebuild queries complete");

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
